// File: rtl/rf_wb_if.sv
// Bundle of the write-back unit's ALU, load-request, memory-response and
// register-file write-port signals.
//   master : the surrounding pipeline / memory (drives requests, sees results)
//   slave  : rf_wb_unit
interface rf_wb_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;

  logic          ld_req_valid;
  logic          ld_req_ready;
  logic [4:0]    ld_req_rd;
  logic [2:0]    ld_req_funct3;
  logic [1:0]    ld_req_off;

  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  logic          rf_wr_en;
  logic [4:0]    rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [31:0]   busy_mask;
  logic          stall;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_off,
    output mem_rsp_valid, mem_rsp_data,
    input  ld_req_ready, rf_wr_en, rf_rd_addr, rf_rd_data, busy_mask, stall
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_off,
    input  mem_rsp_valid, mem_rsp_data,
    output ld_req_ready, rf_wr_en, rf_rd_addr, rf_rd_data, busy_mask, stall
  );
endinterface

// File: rtl/rf_wb_unit.sv
// Register-file write-back unit.
// Merges ALU results and load responses onto the single register-file write
// port, tracks one outstanding load with a busy scoreboard, extends load data
// (LB/LBU/LH/LHU/LW) and stalls upstream on port conflicts and WAW hazards.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rf_wb_if.slave (ALU input, load request, memory response,
//           register-file write port, busy_mask, stall)
module rf_wb_unit #(
  parameter int DW = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  rf_wb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no load outstanding
    WAIT = 2'd1,  // load issued, waiting for memory data
    HOLD = 2'd2   // load data parked while the ALU used the port
  } state_e;

  state_e state_q, state_d;

  logic [4:0]    ld_rd_q,     ld_rd_d;
  logic [2:0]    ld_funct3_q, ld_funct3_d;
  logic [1:0]    ld_off_q,    ld_off_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [31:0]   busy_q,      busy_d;
  logic          wr_en_q,     wr_en_d;
  logic [4:0]    wr_addr_q,   wr_addr_d;
  logic [DW-1:0] wr_data_q,   wr_data_d;

  logic          stall;
  logic          alu_acc;
  logic          ld_acc;
  logic          rsp_in_wait;
  logic [DW-1:0] ext_data;

  // Byte/halfword lane select plus sign/zero extension (DW=32 only).
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // WAW: an ALU write to a register still awaiting load data must wait,
  // otherwise the late load would overwrite the younger ALU result.
  assign stall = (state_q == HOLD) ||
                 (bus.alu_valid && (bus.alu_rd != 5'd0) && busy_q[bus.alu_rd]);

  assign alu_acc     = bus.alu_valid && !stall;
  assign ld_acc      = bus.ld_req_valid && (state_q == IDLE);
  assign rsp_in_wait = bus.mem_rsp_valid && (state_q == WAIT);
  assign ext_data    = extend_load(bus.mem_rsp_data, ld_funct3_q, ld_off_q);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ld_acc)      state_d = WAIT;
      WAIT:    if (rsp_in_wait) state_d = alu_acc ? HOLD : IDLE;
      HOLD:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Output logic (pure function of state for ready; stall also sees ALU inputs).
  always_comb begin
    bus.ld_req_ready = (state_q == IDLE);
    bus.stall        = stall;
  end

  // Datapath next-state: write-port arbitration, hold register, scoreboard.
  always_comb begin
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    hold_data_d = hold_data_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (state_q == HOLD) begin
      // Parked load drains; any ALU request here is a protocol violation
      // and is already blocked by stall.
      wr_en_d         = (ld_rd_q != 5'd0);
      wr_addr_d       = ld_rd_q;
      wr_data_d       = hold_data_q;
      busy_d[ld_rd_q] = 1'b0;
    end else begin
      if (alu_acc) begin
        // x0 writes are accepted but never reach the register file.
        wr_en_d   = (bus.alu_rd != 5'd0);
        wr_addr_d = bus.alu_rd;
        wr_data_d = bus.alu_data;
      end
      if (rsp_in_wait) begin
        if (alu_acc) begin
          hold_data_d = ext_data;
        end else begin
          wr_en_d         = (ld_rd_q != 5'd0);
          wr_addr_d       = ld_rd_q;
          wr_data_d       = ext_data;
          busy_d[ld_rd_q] = 1'b0;
        end
      end
      if (ld_acc) begin
        ld_rd_d     = bus.ld_req_rd;
        ld_funct3_d = bus.ld_req_funct3;
        ld_off_d    = bus.ld_req_off;
        if (bus.ld_req_rd != 5'd0) busy_d[bus.ld_req_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      hold_data_q <= '0;
      busy_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      hold_data_q <= hold_data_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_rd_addr = wr_addr_q;
  assign bus.rf_rd_data = wr_data_q;
  assign bus.busy_mask  = busy_q;

endmodule

// File: tb/tb_rf_wb_unit.sv
// Directed testbench for rf_wb_unit. Inputs change 1 ns after each rising
// edge; registered outputs are sampled there too, combinational ones after
// the inputs settle.
module tb_rf_wb_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rf_wb_if #(.DW(32)) bus ();

  rf_wb_unit #(.DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = 5'd0;
    bus.alu_data      = 32'd0;
    bus.ld_req_valid  = 1'b0;
    bus.ld_req_rd     = 5'd0;
    bus.ld_req_funct3 = 3'd0;
    bus.ld_req_off    = 2'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== 38'd0) begin
      errors++; $display("FAIL reset_rf: got %b/%0d/%h required 0/0/0", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data);
    end
    checks++;
    if ({bus.busy_mask, bus.ld_req_ready, bus.stall} !== {32'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_ctl: busy=%h ready=%b stall=%b required 0/1/0", bus.busy_mask, bus.ld_req_ready, bus.stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL alu_write: got %b/%0d/%h required 1/5/00001234", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data);
    end
    step();
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL alu_one_cycle: wr_en=%b required 0", bus.rf_wr_en); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    step();
    idle_inputs();
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL alu_x0: wr_en=%b required 0", bus.rf_wr_en); end
    step();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] rsp, input logic [31:0] exp_data);
    logic [31:0] exp_busy;
    exp_busy = (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
    bus.ld_req_valid = 1'b1; bus.ld_req_rd = rd; bus.ld_req_funct3 = f3; bus.ld_req_off = off;
    #1;
    checks++;
    if ({bus.ld_req_ready, bus.stall} !== 2'b10) begin
      errors++; $display("FAIL %s_idle: ready=%b stall=%b required 1/0", name, bus.ld_req_ready, bus.stall);
    end
    step();
    idle_inputs();
    checks++;
    if ({bus.busy_mask, bus.ld_req_ready, bus.rf_wr_en} !== {exp_busy, 2'b00}) begin
      errors++; $display("FAIL %s_accept: busy=%h ready=%b wr_en=%b required %h/0/0", name, bus.busy_mask, bus.ld_req_ready, bus.rf_wr_en, exp_busy);
    end
    step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = rsp;
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== {rd != 5'd0, rd, exp_data} ||
        bus.busy_mask !== 32'd0 || bus.ld_req_ready !== 1'b1) begin
      errors++; $display("FAIL %s_write: got %b/%0d/%h busy=%h ready=%b required %b/%0d/%h busy=0 ready=1",
                         name, bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.busy_mask, bus.ld_req_ready, rd != 5'd0, rd, exp_data);
    end
    step();
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL %s_one_cycle: wr_en=%b required 0", name, bus.rf_wr_en); end
  endtask

  task automatic test_conflict();
    bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd3; bus.ld_req_funct3 = 3'b010;
    step();
    idle_inputs();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE0003;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL conflict_pre_stall: stall=%b required 0", bus.stall); end
    step();
    // Protocol-violating ALU request during HOLD must be ignored.
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    #1;
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall, bus.busy_mask[3]} !== {1'b1, 5'd4, 32'h44, 2'b11}) begin
      errors++; $display("FAIL conflict_alu_first: got %b/%0d/%h stall=%b busy3=%b required 1/4/00000044 stall=1 busy3=1",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall, bus.busy_mask[3]);
    end
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall} !== {1'b1, 5'd3, 32'hCAFE0003, 1'b0} || bus.busy_mask !== 32'd0) begin
      errors++; $display("FAIL conflict_load_second: got %b/%0d/%h stall=%b busy=%h required 1/3/cafe0003 stall=0 busy=0",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall, bus.busy_mask);
    end
    step();
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL conflict_hold_alu_dropped: wr_en=%b addr=%0d required 0", bus.rf_wr_en, bus.rf_rd_addr); end
  endtask

  task automatic test_waw();
    bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd9; bus.ld_req_funct3 = 3'b010;
    step();
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: stall=%b required 1", bus.stall); end
    step();
    checks++;
    if ({bus.rf_wr_en, bus.stall} !== 2'b01) begin errors++; $display("FAIL waw_blocked: wr_en=%b stall=%b required 0/1", bus.rf_wr_en, bus.stall); end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h11;
    step();
    bus.mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall} !== {1'b1, 5'd9, 32'h11, 1'b0} || bus.busy_mask !== 32'd0) begin
      errors++; $display("FAIL waw_load: got %b/%0d/%h stall=%b busy=%h required 1/9/00000011 stall=0 busy=0",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.stall, bus.busy_mask);
    end
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd9, 32'h99}) begin
      errors++; $display("FAIL waw_alu: got %b/%0d/%h required 1/9/00000099", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data);
    end
    step();
  endtask

  task automatic test_back_pressure();
    bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd10; bus.ld_req_funct3 = 3'b010;
    step();
    bus.ld_req_rd = 5'd11;
    #1;
    checks++;
    if (bus.ld_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: ready=%b required 0", bus.ld_req_ready); end
    step();
    checks++;
    if (bus.busy_mask !== 32'h0000_0400) begin errors++; $display("FAIL bp_not_captured: busy=%h required 00000400", bus.busy_mask); end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h5;
    step();
    bus.mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.ld_req_ready} !== {1'b1, 5'd10, 32'h5, 1'b1}) begin
      errors++; $display("FAIL bp_first_write: got %b/%0d/%h ready=%b required 1/10/00000005 ready=1",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.ld_req_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (bus.busy_mask !== 32'h0000_0800) begin errors++; $display("FAIL bp_second_accept: busy=%h required 00000800", bus.busy_mask); end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h6;
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd11, 32'h6}) begin
      errors++; $display("FAIL bp_second_write: got %b/%0d/%h required 1/11/00000006", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    // ALU write and load accepted together in IDLE, then reset while WAIT.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd15; bus.alu_data = 32'hF15;
    bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd14; bus.ld_req_funct3 = 3'b010;
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd15, 32'hF15} || bus.busy_mask !== 32'h0000_4000) begin
      errors++; $display("FAIL same_cycle: got %b/%0d/%h busy=%h required 1/15/00000f15 busy=00004000",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.busy_mask);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.busy_mask, bus.ld_req_ready, bus.stall} !== {38'd0, 32'd0, 2'b10}) begin
      errors++; $display("FAIL reset_mid: got %b/%0d/%h busy=%h ready=%b stall=%b required all 0, ready=1",
                         bus.rf_wr_en, bus.rf_rd_addr, bus.rf_rd_data, bus.busy_mask, bus.ld_req_ready, bus.stall);
    end
    #2 rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD;
    step();
    idle_inputs();
    checks++;
    if ({bus.rf_wr_en, bus.busy_mask, bus.ld_req_ready} !== {1'b0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL late_rsp: wr_en=%b busy=%h ready=%b required 0/0/1", bus.rf_wr_en, bus.busy_mask, bus.ld_req_ready);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load("lb",     3'b000, 2'd2, 5'd7,  32'h0080_0000, 32'hFFFF_FF80);
    test_load("lbu",    3'b100, 2'd2, 5'd7,  32'h0080_0000, 32'h0000_0080);
    test_load("lb1",    3'b000, 2'd1, 5'd8,  32'h0000_AB00, 32'hFFFF_FFAB);
    test_load("lb3",    3'b000, 2'd3, 5'd8,  32'h7F00_0000, 32'h0000_007F);
    test_load("lh",     3'b001, 2'd2, 5'd7,  32'h8001_FFFF, 32'hFFFF_8001);
    test_load("lhu",    3'b101, 2'd1, 5'd20, 32'h8001_FFFF, 32'h0000_FFFF);
    test_load("lw",     3'b010, 2'd3, 5'd31, 32'h8001_FFFF, 32'h8001_FFFF);
    test_load("badf3",  3'b111, 2'd1, 5'd2,  32'h1234_5678, 32'h1234_5678);
    test_load("ld_x0",  3'b010, 2'd0, 5'd0,  32'h5555_5555, 32'h5555_5555);
    test_conflict();
    test_waw();
    test_back_pressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
